seq_detect_gen: RTL and testbench

Parametrised serial bit-pattern detector for the FSM library. It generalises the fixed two-ones Mealy detector in four ways: a runtime-programmable pattern of PAT_W bits, selectable overlapping or non-overlapping matching, an input-valid qualifier, and a saturating match counter. It sits beside the serial receive path and produces both a same-cycle Mealy match strobe and a registered match strobe.

---
 rtl/seq_detect_gen_if.sv | 29 ++
 rtl/seq_detect_gen.sv | 108 ++++++++++
 tb/tb_seq_detect_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_gen_if.sv
// Bus bundle for the serial pattern detector: data/config inputs from the
// receive path and the match/count status returned to it.
interface seq_detect_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             cnt_clr;
    logic             out;
    logic             out_q;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    // Driver side: supplies bits and configuration, observes matches
    modport master (
        output in, in_valid, cfg_load, pattern, overlap, cnt_clr,
        input  out, out_q, match_cnt, cnt_sat
    );

    // Detector side
    modport slave (
        input  in, in_valid, cfg_load, pattern, overlap, cnt_clr,
        output out, out_q, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_gen.sv
// Programmable serial bit-pattern detector with overlapping or
// non-overlapping matching, an input-valid qualifier, a Mealy match strobe,
// its registered copy and a saturating match counter with sticky overflow.
module seq_detect_gen #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
    parameter logic             OVL_RST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seq_detect_gen_if.slave  bus
);
    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        ARMED
    } state_t;

    state_t             state_q, state_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic               cnt_sat_q, cnt_sat_d;
    logic               out_q_q, out_q_d;

    logic               consume;
    logic               hit;
    logic [PAT_W-1:0]   window;

    // The candidate pattern is the stored history with the current bit appended
    assign window  = {hist_q, bus.in};
    assign consume = bus.in_valid & ~bus.cfg_load;
    assign hit     = consume & (state_q == ARMED) & (window == pat_q);

    assign bus.out       = hit;
    assign bus.out_q     = out_q_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.cnt_sat   = cnt_sat_q;

    // Next-state: config load restarts detection, consumed bits advance the fill
    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        hist_d      = hist_q;
        pat_d       = pat_q;
        ovl_d       = ovl_q;
        match_cnt_d = match_cnt_q;
        cnt_sat_d   = cnt_sat_q;
        out_q_d     = hit;

        if (bus.cfg_load) begin
            pat_d   = bus.pattern;
            ovl_d   = bus.overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = EMPTY;
        end else if (bus.in_valid) begin
            hist_d = window[PAT_W-2:0];
            if (fill_q < FILL_MAX) begin
                fill_d  = fill_q + 1'b1;
                state_d = ((fill_q + 1'b1) == FILL_MAX) ? ARMED : FILLING;
            end else if (hit && !ovl_q) begin
                fill_d  = '0;
                state_d = EMPTY;
            end
        end

        if (bus.cnt_clr) begin
            match_cnt_d = '0;
            cnt_sat_d   = 1'b0;
        end else if (hit) begin
            if (&match_cnt_q) begin
                cnt_sat_d = 1'b1;
            end else begin
                match_cnt_d = match_cnt_q + 1'b1;
            end
        end
    end

    // All state, config and registered outputs, with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= EMPTY;
            fill_q      <= '0;
            hist_q      <= '0;
            pat_q       <= PAT_RST;
            ovl_q       <= OVL_RST;
            match_cnt_q <= '0;
            cnt_sat_q   <= 1'b0;
            out_q_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            hist_q      <= hist_d;
            pat_q       <= pat_d;
            ovl_q       <= ovl_d;
            match_cnt_q <= match_cnt_d;
            cnt_sat_q   <= cnt_sat_d;
            out_q_q     <= out_q_d;
        end
    end
endmodule

// File: tb/tb_seq_detect_gen.sv
// Self-checking bench for seq_detect_gen: directed scenarios followed by a
// randomized stream, all compared against a queue-based reference model.
module tb_seq_detect_gen;
    localparam int               PAT_W   = 4;
    localparam int               CNT_W   = 2;
    localparam logic [PAT_W-1:0] PAT_RST = 4'b1011;
    localparam int               CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_pass   = 0;

    seq_detect_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detect_gen #(
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W),
        .PAT_RST(PAT_RST),
        .OVL_RST(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the bits consumed since the last restart, the active
    // configuration, and the counter as plain integers
    logic [PAT_W-1:0] m_pat;
    logic             m_ovl;
    bit               m_bits[$];
    int               m_cnt;
    logic             m_sat;
    logic             m_outq;

    function automatic void model_reset();
        m_pat  = PAT_RST;
        m_ovl  = 1'b1;
        m_bits.delete();
        m_cnt  = 0;
        m_sat  = 1'b0;
        m_outq = 1'b0;
    endfunction

    // A match needs PAT_W-1 remembered bits plus the current bit equal to the pattern
    function automatic logic model_hit(logic b, logic v, logic l);
        logic [PAT_W-1:0] val;
        if (!v || l) return 1'b0;
        if (m_bits.size() < PAT_W - 1) return 1'b0;
        val = '0;
        foreach (m_bits[k]) val = {val[PAT_W-2:0], m_bits[k]};
        val = {val[PAT_W-2:0], b};
        return val == m_pat;
    endfunction

    // Advance the model across one clock edge
    function automatic void model_step(logic b, logic v, logic l,
                                       logic [PAT_W-1:0] p, logic o, logic c);
        logic h;
        h = model_hit(b, v, l);
        if (l) begin
            m_pat = p;
            m_ovl = o;
            m_bits.delete();
        end else if (v) begin
            if (h && !m_ovl) begin
                m_bits.delete();
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
            end
        end
        if (c) begin
            m_cnt = 0;
            m_sat = 1'b0;
        end else if (h) begin
            if (m_cnt == CNT_MAX) m_sat = 1'b1;
            else                  m_cnt = m_cnt + 1;
        end
        m_outq = h;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check the Mealy output
    // before the rising edge, then check the registered outputs just after it
    task automatic applyStimulus(logic b, logic v, logic l,
                                 logic [PAT_W-1:0] p, logic o, logic c);
        @(negedge clk);
        bus.in       = b;
        bus.in_valid = v;
        bus.cfg_load = l;
        bus.pattern  = p;
        bus.overlap  = o;
        bus.cnt_clr  = c;
        #1;
        checkOutput("out", 32'(bus.out), 32'(model_hit(b, v, l)));
        @(posedge clk);
        model_step(b, v, l, p, o, c);
        #1;
        checkOutput("out_q", 32'(bus.out_q), 32'(m_outq));
        checkOutput("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
        checkOutput("cnt_sat", 32'(bus.cnt_sat), 32'(m_sat));
    endtask

    // Convenience wrappers for a plain valid bit and a config load with clear
    task automatic sendBit(logic b);
        applyStimulus(b, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic loadCfg(logic [PAT_W-1:0] p, logic o);
        applyStimulus(1'b0, 1'b0, 1'b1, p, o, 1'b1);
    endtask

    // Watchdog so the run always ends even if something stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence: reset defaults, the directed scenarios, then random traffic
    initial begin
        logic [6:0]       stream7;
        logic             rb, rv, rl, ro, rc;
        logic [PAT_W-1:0] rp;

        stream7      = 7'b1011011;
        rst          = 1'b0;
        bus.in       = 1'b0;
        bus.in_valid = 1'b0;
        bus.cfg_load = 1'b0;
        bus.pattern  = '0;
        bus.overlap  = 1'b0;
        bus.cnt_clr  = 1'b0;
        model_reset();

        #2;
        checkOutput("rst_out", 32'(bus.out), 32'd0);
        checkOutput("rst_out_q", 32'(bus.out_q), 32'd0);
        checkOutput("rst_cnt", 32'(bus.match_cnt), 32'd0);
        checkOutput("rst_sat", 32'(bus.cnt_sat), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] default pattern, overlapping");
        for (int i = 6; i >= 0; i--) sendBit(stream7[i]);
        checkOutput("t1_cnt", 32'(bus.match_cnt), 32'd2);

        $display("[TB] non-overlapping");
        loadCfg(4'b1011, 1'b0);
        for (int i = 6; i >= 0; i--) sendBit(stream7[i]);
        checkOutput("t2_cnt", 32'(bus.match_cnt), 32'd1);

        $display("[TB] valid gaps");
        loadCfg(4'b1011, 1'b1);
        for (int i = 6; i >= 3; i--) begin
            sendBit(stream7[i]);
            applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        checkOutput("t3_cnt", 32'(bus.match_cnt), 32'd1);

        $display("[TB] counter saturation");
        loadCfg(4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) sendBit(1'b1);
        checkOutput("t4_cnt6", 32'(bus.match_cnt), 32'd3);
        checkOutput("t4_sat6", 32'(bus.cnt_sat), 32'd0);
        sendBit(1'b1);
        checkOutput("t4_cnt7", 32'(bus.match_cnt), 32'd3);
        checkOutput("t4_sat7", 32'(bus.cnt_sat), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkOutput("t4_clr_cnt", 32'(bus.match_cnt), 32'd0);
        checkOutput("t4_clr_sat", 32'(bus.cnt_sat), 32'd0);

        $display("[TB] asynchronous reset mid-pattern");
        loadCfg(4'b1011, 1'b1);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
        sendBit(1'b0); sendBit(1'b1);
        @(negedge clk);
        bus.in       = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        checkOutput("t5_pre_out", 32'(bus.out), 32'd1);
        checkOutput("t5_pre_cnt", 32'(bus.match_cnt), 32'd1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checkOutput("t5_out", 32'(bus.out), 32'd0);
        checkOutput("t5_out_q", 32'(bus.out_q), 32'd0);
        checkOutput("t5_cnt", 32'(bus.match_cnt), 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sendBit(1'b1);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
        checkOutput("t5_after_cnt", 32'(bus.match_cnt), 32'd1);

        $display("[TB] cfg_load on a completing bit");
        loadCfg(4'b1011, 1'b1);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
        checkOutput("t6_load_cnt", 32'(bus.match_cnt), 32'd0);
        sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b0);
        checkOutput("t6_new_cnt", 32'(bus.match_cnt), 32'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            rb = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 9) < 8);
            rl = ($urandom_range(0, 39) == 0);
            rp = PAT_W'($urandom);
            ro = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 24) == 0);
            applyStimulus(rb, rv, rl, rp, ro, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
